// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_unit
// Brief    : Turns resolved branches/jumps into a one-cycle fetch redirect
//            pulse with a held target PC, and squashes IF/ID and ID/EX over
//            the wrong-path window.
// Revision : 1.0
// ============================================================================
module branch_redirect_unit #(
    parameter int instructionSize = 24,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       brValid,
    input  logic                       brTaken,
    input  logic                       brAbsolute,
    input  logic [instructionSize-9:0] brPc,
    input  logic [instructionSize-9:0] brOffset,
    input  logic [instructionSize-9:0] brTarget,
    output logic                       pcWrEn,
    output logic [instructionSize-9:0] newPc,
    output logic                       flushIfId,
    output logic                       flushIdEx,
    output logic                       busy
);

    localparam int W     = instructionSize - 8;
    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pc_wr_en;
    logic [W-1:0]     r_new_pc;
    logic             r_flush;
    logic             r_busy;

    logic             w_redirect;
    logic [W-1:0]     w_rel_tgt;
    logic [W-1:0]     w_tgt;

    assign w_redirect = brValid & (brAbsolute | brTaken);
    assign w_rel_tgt  = brPc + brOffset;
    // Targets are always word aligned; the low two bits are dropped.
    assign w_tgt      = brAbsolute ? {brTarget[W-1:2], 2'b00} : {w_rel_tgt[W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pc_wr_en <= 1'b0;
            r_new_pc   <= '0;
            r_flush    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redirect) begin
                        r_state    <= S_REDIRECT;
                        r_pc_wr_en <= 1'b1;
                        r_new_pc   <= w_tgt;
                        r_flush    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    r_pc_wr_en <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= C_CNT_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Incoming brValid here is wrong-path and deliberately ignored.
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_pc_wr_en <= 1'b0;
                    r_flush    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign pcWrEn    = r_pc_wr_en;
    assign newPc     = r_new_pc;
    assign flushIfId = r_flush;
    assign flushIdEx = r_flush;
    assign busy      = r_busy;

endmodule
`default_nettype wire
